// File: rtl/axi_rw_sched.sv
// rtl/axi_rw_sched.sv - one-burst-at-a-time scheduler between the AXI controller and the write/read masters
//
// Purpose: accepts level-held write/read burst requests from the controller,
// grants one direction at a time (round-robin or fixed priority), forwards the
// latched address/length to the matching master and holds the grant until the
// master reports completion. A watchdog aborts a burst that overstays TIMEOUT
// cycles. Per-direction completed-burst counters are provided.
//
// Parameters:
//   PRIO     0 = round-robin, 1 = read fixed priority, 2 = write fixed priority
//   TIMEOUT  max cycles spent in ISSUE+WAIT for one burst, 0 disables watchdog
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   c_wr_start_i/addr_i/len_i       controller write request (level) + burst params
//   c_wr_ready_o                    low while the controller's write burst is in progress
//   c_rd_start_i/addr_i/len_i       controller read request (level) + burst params
//   c_rd_ready_o                    low while the controller's read burst is in progress
//   m_wr_start_o/addr_o/len_o       write master start + latched burst params
//   m_wr_ready_i                    write master ready (low = accepted/running)
//   m_rd_start_o/addr_o/len_o       read master start + latched burst params
//   m_rd_ready_i                    read master ready (low = accepted/running)
//   busy_o                          a burst is granted
//   grant_rd_o                      current or last grant was read
//   timeout_err_o                   sticky watchdog flag
//   wr_burst_cnt_o, rd_burst_cnt_o  completed burst counters (wrapping)

module axi_rw_sched #(
  parameter int PRIO    = 0,
  parameter int TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_wr_start_i,
  input  logic [29:0] c_wr_addr_i,
  input  logic [7:0]  c_wr_len_i,
  output logic        c_wr_ready_o,
  input  logic        c_rd_start_i,
  input  logic [29:0] c_rd_addr_i,
  input  logic [7:0]  c_rd_len_i,
  output logic        c_rd_ready_o,
  output logic        m_wr_start_o,
  output logic [29:0] m_wr_addr_o,
  output logic [7:0]  m_wr_len_o,
  input  logic        m_wr_ready_i,
  output logic        m_rd_start_o,
  output logic [29:0] m_rd_addr_o,
  output logic [7:0]  m_rd_len_o,
  input  logic        m_rd_ready_i,
  output logic        busy_o,
  output logic        grant_rd_o,
  output logic        timeout_err_o,
  output logic [15:0] wr_burst_cnt_o,
  output logic [15:0] rd_burst_cnt_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ISSUE = 3'd1,
    WR_WAIT  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4
  } state_e;

  localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);
  localparam bit          WdEnable   = (TIMEOUT != 0);

  state_e      state_q;
  logic        c_wr_ready_q, c_rd_ready_q;
  logic        m_wr_start_q, m_rd_start_q;
  logic [29:0] m_wr_addr_q, m_rd_addr_q;
  logic [7:0]  m_wr_len_q, m_rd_len_q;
  logic        busy_q, grant_rd_q, timeout_err_q;
  logic [15:0] wr_cnt_q, rd_cnt_q;
  logic [15:0] wd_q;

  logic        wr_elig, rd_elig, pick_rd, wd_fire;
  logic [15:0] wd_d;

  always_comb begin
    wr_elig = c_wr_start_i & m_wr_ready_i;
    rd_elig = c_rd_start_i & m_rd_ready_i;
    pick_rd = rd_elig;
    if (wr_elig && rd_elig) begin
      case (PRIO)
        1:       pick_rd = 1'b1;
        2:       pick_rd = 1'b0;
        default: pick_rd = ~grant_rd_q;   // round-robin: flip the last grant
      endcase
    end
    // The watchdog compares the value it is about to hold, so a burst may
    // occupy ISSUE+WAIT for exactly TIMEOUT cycles before it is aborted.
    wd_d    = wd_q + 16'd1;
    wd_fire = WdEnable && (wd_d == TimeoutVal);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      c_wr_ready_q  <= 1'b1;
      c_rd_ready_q  <= 1'b1;
      m_wr_start_q  <= 1'b0;
      m_rd_start_q  <= 1'b0;
      m_wr_addr_q   <= '0;
      m_wr_len_q    <= '0;
      m_rd_addr_q   <= '0;
      m_rd_len_q    <= '0;
      busy_q        <= 1'b0;
      grant_rd_q    <= 1'b1;   // first round-robin grant goes to write
      timeout_err_q <= 1'b0;
      wr_cnt_q      <= '0;
      rd_cnt_q      <= '0;
      wd_q          <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_elig || rd_elig) begin
            busy_q     <= 1'b1;
            wd_q       <= '0;
            grant_rd_q <= pick_rd;
            if (pick_rd) begin
              m_rd_addr_q  <= c_rd_addr_i;
              m_rd_len_q   <= c_rd_len_i;
              m_rd_start_q <= 1'b1;
              c_rd_ready_q <= 1'b0;
              state_q      <= RD_ISSUE;
            end else begin
              m_wr_addr_q  <= c_wr_addr_i;
              m_wr_len_q   <= c_wr_len_i;
              m_wr_start_q <= 1'b1;
              c_wr_ready_q <= 1'b0;
              state_q      <= WR_ISSUE;
            end
          end
        end
        WR_ISSUE: begin
          wd_q <= wd_d;
          if (wd_fire) begin
            timeout_err_q <= 1'b1;
            m_wr_start_q  <= 1'b0;
            c_wr_ready_q  <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end else if (!m_wr_ready_i) begin
            m_wr_start_q <= 1'b0;
            state_q      <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          wd_q <= wd_d;
          // A completion seen on the watchdog's last cycle still counts.
          if (m_wr_ready_i) begin
            c_wr_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            wr_cnt_q     <= wr_cnt_q + 16'd1;
            state_q      <= IDLE;
          end else if (wd_fire) begin
            timeout_err_q <= 1'b1;
            c_wr_ready_q  <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end
        end
        RD_ISSUE: begin
          wd_q <= wd_d;
          if (wd_fire) begin
            timeout_err_q <= 1'b1;
            m_rd_start_q  <= 1'b0;
            c_rd_ready_q  <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end else if (!m_rd_ready_i) begin
            m_rd_start_q <= 1'b0;
            state_q      <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          wd_q <= wd_d;
          if (m_rd_ready_i) begin
            c_rd_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            rd_cnt_q     <= rd_cnt_q + 16'd1;
            state_q      <= IDLE;
          end else if (wd_fire) begin
            timeout_err_q <= 1'b1;
            c_rd_ready_q  <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign c_wr_ready_o   = c_wr_ready_q;
  assign c_rd_ready_o   = c_rd_ready_q;
  assign m_wr_start_o   = m_wr_start_q;
  assign m_wr_addr_o    = m_wr_addr_q;
  assign m_wr_len_o     = m_wr_len_q;
  assign m_rd_start_o   = m_rd_start_q;
  assign m_rd_addr_o    = m_rd_addr_q;
  assign m_rd_len_o     = m_rd_len_q;
  assign busy_o         = busy_q;
  assign grant_rd_o     = grant_rd_q;
  assign timeout_err_o  = timeout_err_q;
  assign wr_burst_cnt_o = wr_cnt_q;
  assign rd_burst_cnt_o = rd_cnt_q;

endmodule
